usb_bus_ctrl: RTL and testbench



---
 rtl/usb_utmi_pkg.sv | 24 ++
 rtl/usb_line_timer.sv | 30 +++
 rtl/usb_bus_ctrl.sv | 134 +++++++++++++
 tb/tb_usb_bus_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_utmi_pkg.sv
// Shared UTMI line-state and USB bus-state types plus 48 MHz bus timing constants.
package usb_utmi_pkg;

    typedef enum logic [1:0] {
        LS_SE0 = 2'b00,
        LS_J   = 2'b01,
        LS_K   = 2'b10,
        LS_SE1 = 2'b11
    } utmi_line_state_t;

    typedef enum logic [2:0] {
        ACTIVE_S  = 3'd0,
        RESET_S   = 3'd1,
        SUSPEND_S = 3'd2,
        RESUME_S  = 3'd3,
        WAKEUP_S  = 3'd4
    } usb_bus_state_t;

    localparam int unsigned USB_RESET_CYCLES_48M   = 120;
    localparam int unsigned USB_SUSPEND_CYCLES_48M = 144000;
    localparam int unsigned USB_RESUME_CYCLES_48M  = 48;
    localparam int unsigned USB_WAKEUP_CYCLES_48M  = 96000;

endpackage

// File: rtl/usb_line_timer.sv
// Saturating run-length timer: hit is high once cond has held for CYCLES consecutive cycles.
module usb_line_timer #(
    parameter int unsigned CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic cond,
    input  logic clr,
    output logic hit
);

    localparam int unsigned CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] HIT_VAL = CW'(CYCLES - 1);

    logic [CW-1:0] r_cnt;

    // Holds at the hit value instead of wrapping so a long condition keeps hitting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr || !cond) begin
            r_cnt <= '0;
        end else if (r_cnt != HIT_VAL) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign hit = cond && !clr && (r_cnt == HIT_VAL);

endmodule

// File: rtl/usb_bus_ctrl.sv
// Full-speed USB bus-event controller: bus reset, suspend and resume detection.
// Remote wakeup (wakeup_req/drive_k, WAKEUP_S) is built only with USB_REMOTE_WAKEUP_EN.
module usb_bus_ctrl
    import usb_utmi_pkg::*;
#(
    parameter int unsigned RESET_CYCLES   = USB_RESET_CYCLES_48M,
    parameter int unsigned SUSPEND_CYCLES = USB_SUSPEND_CYCLES_48M,
    parameter int unsigned RESUME_CYCLES  = USB_RESUME_CYCLES_48M,
    parameter int unsigned WAKEUP_CYCLES  = USB_WAKEUP_CYCLES_48M
) (
    input  logic             clk,
    input  logic             rst,
    input  utmi_line_state_t line_state,
    input  logic             rx_active,
    input  logic             tx_active,
    output logic             suspend_m,
    output logic             usb_reset,
    output logic             suspended,
    output logic             resume_pulse,
    output usb_bus_state_t   bus_state
`ifdef USB_REMOTE_WAKEUP_EN
    ,
    input  logic             wakeup_req,
    output logic             drive_k
`endif
);

    usb_bus_state_t r_state;
    usb_bus_state_t w_next;
    logic           r_resume_pulse;
    logic           w_resume_set;
    logic           w_clr;
    logic           w_se0_hit;
    logic           w_idle_hit;
    logic           w_k_hit;

    // Leaving RESET_S starts every run from zero; RESET_S is only left on non-SE0.
    assign w_clr = (r_state == RESET_S);

    usb_line_timer #(.CYCLES(RESET_CYCLES)) u_se0_timer (
        .clk  (clk),
        .rst  (rst),
        .cond (line_state == LS_SE0),
        .clr  (w_clr),
        .hit  (w_se0_hit)
    );

    usb_line_timer #(.CYCLES(SUSPEND_CYCLES)) u_idle_timer (
        .clk  (clk),
        .rst  (rst),
        .cond ((line_state == LS_J) && !rx_active && !tx_active),
        .clr  (w_clr),
        .hit  (w_idle_hit)
    );

    usb_line_timer #(.CYCLES(RESUME_CYCLES)) u_k_timer (
        .clk  (clk),
        .rst  (rst),
        .cond (line_state == LS_K),
        .clr  (w_clr),
        .hit  (w_k_hit)
    );

`ifdef USB_REMOTE_WAKEUP_EN
    logic w_wake_hit;

    usb_line_timer #(.CYCLES(WAKEUP_CYCLES)) u_wake_timer (
        .clk  (clk),
        .rst  (rst),
        .cond (r_state == WAKEUP_S),
        .clr  (r_state != WAKEUP_S),
        .hit  (w_wake_hit)
    );

    assign drive_k = (r_state == WAKEUP_S);
`else
    logic w_unused_wakeup;
    assign w_unused_wakeup = ^32'(WAKEUP_CYCLES);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ACTIVE_S;
            r_resume_pulse <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_resume_pulse <= w_resume_set;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_resume_set = 1'b0;
        case (r_state)
            ACTIVE_S: begin
                if (w_se0_hit)       w_next = RESET_S;
                else if (w_idle_hit) w_next = SUSPEND_S;
            end
            RESET_S: begin
                if (line_state != LS_SE0) w_next = ACTIVE_S;
            end
            SUSPEND_S: begin
                if (w_se0_hit)    w_next = RESET_S;
                else if (w_k_hit) w_next = RESUME_S;
`ifdef USB_REMOTE_WAKEUP_EN
                else if (wakeup_req) w_next = WAKEUP_S;
`endif
            end
            RESUME_S: begin
                if (w_se0_hit) begin
                    w_next = RESET_S;
                end else if (line_state == LS_J) begin
                    w_next       = ACTIVE_S;
                    w_resume_set = 1'b1;
                end
            end
            WAKEUP_S: begin
`ifdef USB_REMOTE_WAKEUP_EN
                if (w_wake_hit) w_next = RESUME_S;
`else
                w_next = ACTIVE_S;
`endif
            end
            default: w_next = ACTIVE_S;
        endcase
    end

    assign usb_reset    = (r_state == RESET_S);
    assign suspended    = (r_state == SUSPEND_S);
    assign suspend_m    = (r_state != SUSPEND_S);
    assign resume_pulse = r_resume_pulse;
    assign bus_state    = r_state;

endmodule

// File: tb/tb_usb_bus_ctrl.sv
// Self-checking bench for usb_bus_ctrl: run-length reference model plus directed vectors.
// Remote-wakeup scenarios are compiled in when USB_REMOTE_WAKEUP_EN is defined.
module tb_usb_bus_ctrl;
    import usb_utmi_pkg::*;

    localparam int unsigned R_CYC = 8;
    localparam int unsigned S_CYC = 32;
    localparam int unsigned K_CYC = 4;
    localparam int unsigned W_CYC = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    utmi_line_state_t line_state = LS_J;
    logic             rx_active = 1'b1;
    logic             tx_active = 1'b0;
    logic             suspend_m;
    logic             usb_reset;
    logic             suspended;
    logic             resume_pulse;
    usb_bus_state_t   bus_state;
`ifdef USB_REMOTE_WAKEUP_EN
    logic             wakeup_req = 1'b0;
    logic             drive_k;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    usb_bus_ctrl #(
        .RESET_CYCLES   (R_CYC),
        .SUSPEND_CYCLES (S_CYC),
        .RESUME_CYCLES  (K_CYC),
        .WAKEUP_CYCLES  (W_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .line_state   (line_state),
        .rx_active    (rx_active),
        .tx_active    (tx_active),
        .suspend_m    (suspend_m),
        .usb_reset    (usb_reset),
        .suspended    (suspended),
        .resume_pulse (resume_pulse),
        .bus_state    (bus_state)
`ifdef USB_REMOTE_WAKEUP_EN
        ,
        .wakeup_req   (wakeup_req),
        .drive_k      (drive_k)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks run lengths of each line condition and applies the state rules.
    usb_bus_state_t m_state = ACTIVE_S;
    usb_bus_state_t m_nxt;
    logic           m_pulse = 1'b0;
    int             se0_run = 0;
    int             idle_run = 0;
    int             k_run = 0;
    int             wk_run = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_state = ACTIVE_S;
            m_pulse = 1'b0;
            se0_run = 0;
            idle_run = 0;
            k_run = 0;
            wk_run = 0;
        end else begin
            se0_run  = (line_state == LS_SE0) ? se0_run + 1 : 0;
            idle_run = (line_state == LS_J && !rx_active && !tx_active) ? idle_run + 1 : 0;
            k_run    = (line_state == LS_K) ? k_run + 1 : 0;
            wk_run   = (m_state == WAKEUP_S) ? wk_run + 1 : 0;
            m_pulse  = 1'b0;
            m_nxt    = m_state;
            case (m_state)
                ACTIVE_S: begin
                    if (se0_run >= int'(R_CYC)) m_nxt = RESET_S;
                    else if (idle_run >= int'(S_CYC)) m_nxt = SUSPEND_S;
                end
                RESET_S: if (line_state != LS_SE0) m_nxt = ACTIVE_S;
                SUSPEND_S: begin
                    if (se0_run >= int'(R_CYC)) m_nxt = RESET_S;
                    else if (k_run >= int'(K_CYC)) m_nxt = RESUME_S;
`ifdef USB_REMOTE_WAKEUP_EN
                    else if (wakeup_req) m_nxt = WAKEUP_S;
`endif
                end
                RESUME_S: begin
                    if (se0_run >= int'(R_CYC)) m_nxt = RESET_S;
                    else if (line_state == LS_J) begin
                        m_nxt   = ACTIVE_S;
                        m_pulse = 1'b1;
                    end
                end
                WAKEUP_S: if (wk_run >= int'(W_CYC)) m_nxt = RESUME_S;
                default: m_nxt = ACTIVE_S;
            endcase
            if (m_state == RESET_S) begin
                se0_run  = 0;
                idle_run = 0;
                k_run    = 0;
            end
            m_state = m_nxt;
        end
    end

    // Cycle-by-cycle comparison against the model while out of reset.
    always @(negedge clk) begin
        if (rst) begin
            chk("cmp_state", 32'(bus_state), 32'(m_state));
            chk("cmp_usb_reset", 32'(usb_reset), 32'(m_state == RESET_S));
            chk("cmp_suspended", 32'(suspended), 32'(m_state == SUSPEND_S));
            chk("cmp_suspend_m", 32'(suspend_m), 32'(m_state != SUSPEND_S));
            chk("cmp_resume_pulse", 32'(resume_pulse), 32'(m_pulse));
`ifdef USB_REMOTE_WAKEUP_EN
            chk("cmp_drive_k", 32'(drive_k), 32'(m_state == WAKEUP_S));
`endif
        end
    end

    task automatic cyc(input utmi_line_state_t ls, input logic rx, input int n);
        for (int i = 0; i < n; i++) begin
            line_state = ls;
            rx_active  = rx;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

`ifdef USB_REMOTE_WAKEUP_EN
    int k_len;
`endif

    initial begin
        #2;
        chk("rst_suspend_m", 32'(suspend_m), 32'd1);
        chk("rst_usb_reset", 32'(usb_reset), 32'd0);
        chk("rst_suspended", 32'(suspended), 32'd0);
        chk("rst_resume_pulse", 32'(resume_pulse), 32'd0);
        chk("rst_state", 32'(bus_state), 32'(ACTIVE_S));
        do_reset();
        cyc(LS_J, 1'b1, 2);

        cyc(LS_SE0, 1'b0, 7);
        chk("se0_7_no_reset", 32'(usb_reset), 32'd0);
        cyc(LS_SE0, 1'b0, 1);
        chk("se0_8_reset", 32'(usb_reset), 32'd1);
        chk("se0_8_state", 32'(bus_state), 32'(RESET_S));
        cyc(LS_SE0, 1'b0, 3);
        chk("reset_held", 32'(usb_reset), 32'd1);
        cyc(LS_J, 1'b1, 1);
        chk("reset_release", 32'(usb_reset), 32'd0);

        cyc(LS_SE0, 1'b0, 7);
        cyc(LS_J, 1'b1, 1);
        chk("short_se0", 32'(usb_reset), 32'd0);

        cyc(LS_J, 1'b0, 19);
        cyc(LS_J, 1'b1, 1);
        cyc(LS_J, 1'b0, 31);
        chk("idle_restart", 32'(suspended), 32'd0);
        cyc(LS_J, 1'b0, 1);
        chk("suspend_in", 32'(suspended), 32'd1);
        chk("suspend_m_low", 32'(suspend_m), 32'd0);

        cyc(LS_K, 1'b0, 3);
        cyc(LS_J, 1'b0, 2);
        chk("k_glitch", 32'(suspended), 32'd1);

        cyc(LS_K, 1'b0, 3);
        chk("k3_still_susp", 32'(suspend_m), 32'd0);
        cyc(LS_K, 1'b0, 1);
        chk("k_hit_suspend_m", 32'(suspend_m), 32'd1);
        chk("k_hit_state", 32'(bus_state), 32'(RESUME_S));
        cyc(LS_SE0, 1'b0, 2);
        chk("ls_eop_state", 32'(bus_state), 32'(RESUME_S));
        chk("ls_eop_no_pulse", 32'(resume_pulse), 32'd0);
        cyc(LS_J, 1'b0, 1);
        chk("resume_pulse_hi", 32'(resume_pulse), 32'd1);
        chk("resume_active", 32'(bus_state), 32'(ACTIVE_S));
        cyc(LS_J, 1'b1, 1);
        chk("resume_pulse_lo", 32'(resume_pulse), 32'd0);

        cyc(LS_J, 1'b0, 32);
        chk("susp_again", 32'(suspended), 32'd1);
        cyc(LS_SE0, 1'b0, 8);
        chk("susp_reset", 32'(usb_reset), 32'd1);
        chk("susp_reset_m", 32'(suspend_m), 32'd1);
        cyc(LS_J, 1'b1, 1);

        tx_active = 1'b1;
        cyc(LS_J, 1'b0, 40);
        chk("tx_blocks_idle", 32'(suspended), 32'd0);
        tx_active = 1'b0;

        cyc(LS_J, 1'b0, 20);
        cyc(LS_SE1, 1'b0, 1);
        cyc(LS_J, 1'b0, 31);
        chk("se1_clears", 32'(suspended), 32'd0);
        chk("se1_state", 32'(bus_state), 32'(ACTIVE_S));
        cyc(LS_J, 1'b0, 1);
        chk("se1_then_susp", 32'(suspended), 32'd1);
        cyc(LS_SE1, 1'b0, 2);
        chk("se1_no_trans", 32'(suspended), 32'd1);

        rst = 1'b0;
        #1;
        chk("midrst_suspend_m", 32'(suspend_m), 32'd1);
        chk("midrst_suspended", 32'(suspended), 32'd0);
        chk("midrst_state", 32'(bus_state), 32'(ACTIVE_S));
        @(posedge clk);
        #1;
        rst = 1'b1;

`ifdef USB_REMOTE_WAKEUP_EN
        cyc(LS_J, 1'b0, 32);
        chk("wk_susp", 32'(suspended), 32'd1);
        wakeup_req = 1'b1;
        cyc(LS_J, 1'b0, 1);
        wakeup_req = 1'b0;
        chk("wk_drive_on", 32'(drive_k), 32'd1);
        chk("wk_suspend_m", 32'(suspend_m), 32'd1);
        k_len = 0;
        for (int i = 0; i < 40 && drive_k; i++) begin
            k_len++;
            cyc(LS_K, 1'b0, 1);
        end
        chk("wk_len", 32'(k_len), 32'(W_CYC));
        chk("wk_to_resume", 32'(bus_state), 32'(RESUME_S));
        cyc(LS_J, 1'b0, 1);
        chk("wk_resume_pulse", 32'(resume_pulse), 32'd1);

        cyc(LS_J, 1'b0, 32);
        wakeup_req = 1'b1;
        cyc(LS_J, 1'b0, 1);
        wakeup_req = 1'b0;
        cyc(LS_K, 1'b0, 5);
        rst = 1'b0;
        #1;
        chk("wk_rst_drive_k", 32'(drive_k), 32'd0);
        chk("wk_rst_state", 32'(bus_state), 32'(ACTIVE_S));
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(LS_J, 1'b1, 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
